// File: rtl/switch_pkg.sv
// Shared types and sizing rules for the switch allocation path.
package switch_pkg;

  typedef enum logic {SA_IDLE, SA_BUSY} sa_state_t;

  // Select width for N sources; a single source still gets one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return $clog2(n) + ((n == 1) ? 1 : 0);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Allocator-to-crossbar handshake: per-buffer valid in, per-(outport, VC) select/enable out.
interface switch_allocator_if import switch_pkg::*; #(
  parameter int unsigned NUM_BUFFERS  = 4,
  parameter int unsigned NUM_OUTPORTS = 4,
  parameter int unsigned NUM_VCS      = 2
) ();

  localparam int unsigned SELECT_SIZE = sel_width(NUM_BUFFERS);

  logic [NUM_BUFFERS-1:0]                                    valid;
  logic                                                      reg_bank_claim;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SELECT_SIZE-1:0]     select;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                      enable;

  modport allocator (
    input  valid,
    input  reg_bank_claim,
    output select,
    output enable
  );

  modport datapath (
    output valid,
    output reg_bank_claim,
    input  select,
    input  enable
  );

endinterface

// File: rtl/switch_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module switch_rr_arbiter import switch_pkg::*; #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = sel_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_valid
);

  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] pos;
    idx        = 0;
    pos        = '0;
    winner     = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps non-power-of-two request counts correct.
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pos = IDX_W'(idx);
      if (!any_valid && req[pos]) begin
        any_valid   = 1'b1;
        winner[pos] = 1'b1;
        winner_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocation: per-(outport, VC) round-robin grant, locked to the winning buffer
// until its valid drops.
module switch_allocator import switch_pkg::*; #(
  parameter int unsigned NUM_BUFFERS  = 4,
  parameter int unsigned NUM_OUTPORTS = 4,
  parameter int unsigned NUM_VCS      = 2
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic [NUM_BUFFERS-1:0]                                    req,
  input  logic [NUM_BUFFERS-1:0][sel_width(NUM_OUTPORTS)-1:0]       req_outport,
  input  logic [NUM_BUFFERS-1:0][sel_width(NUM_VCS)-1:0]            req_vc,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                      credit_avail,
  output logic [NUM_BUFFERS-1:0]                                    grant,
  switch_allocator_if.allocator                                     sa_if
);

  localparam int unsigned SEL_W     = sel_width(NUM_BUFFERS);
  localparam int unsigned OP_W      = sel_width(NUM_OUTPORTS);
  localparam int unsigned VC_W      = sel_width(NUM_VCS);
  localparam int unsigned NUM_PAIRS = NUM_OUTPORTS * NUM_VCS;

  logic [NUM_PAIRS-1:0]                               pair_busy;
  logic [NUM_PAIRS-1:0][SEL_W-1:0]                    pair_owner;
  logic [NUM_PAIRS-1:0][NUM_BUFFERS-1:0]              pair_win;
  logic [NUM_BUFFERS-1:0]                             owned;
  logic [NUM_BUFFERS-1:0]                             grant_d;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SEL_W-1:0]    select_w;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]               enable_w;

  // A buffer holding any pair (including one in its release cycle) may not compete.
  always_comb begin
    owned = '0;
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      if (pair_busy[p]) owned[pair_owner[p]] = 1'b1;
    end
  end

  always_comb begin
    grant_d = '0;
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      grant_d = grant_d | pair_win[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) grant <= '0;
    else     grant <= grant_d;
  end

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_op
    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      localparam int unsigned P = o * NUM_VCS + v;

      sa_state_t              state_q, state_d;
      logic [SEL_W-1:0]       owner_q, owner_d;
      logic [SEL_W-1:0]       ptr_q, ptr_d;
      logic [NUM_BUFFERS-1:0] cand;
      logic [NUM_BUFFERS-1:0] win_oh;
      logic [NUM_BUFFERS-1:0] win_pulse;
      logic [SEL_W-1:0]       win_idx;
      logic                   win_any;

      always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
          cand[i] = req[i] && (req_outport[i] == OP_W'(o)) &&
                    (req_vc[i] == VC_W'(v)) && !owned[i];
        end
      end

      switch_rr_arbiter #(.NUM_REQ(NUM_BUFFERS)) u_arb (
        .req        (cand),
        .ptr        (ptr_q),
        .winner     (win_oh),
        .winner_idx (win_idx),
        .any_valid  (win_any)
      );

      always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        win_pulse = '0;
        case (state_q)
          SA_IDLE: begin
            if (win_any && !sa_if.reg_bank_claim) begin
              state_d   = SA_BUSY;
              owner_d   = win_idx;
              ptr_d     = (win_idx == SEL_W'(NUM_BUFFERS - 1)) ? '0 : win_idx + 1'b1;
              win_pulse = win_oh;
            end
          end
          SA_BUSY: begin
            if (!sa_if.valid[owner_q]) state_d = SA_IDLE;
          end
          default: state_d = SA_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= SA_IDLE;
          owner_q <= '0;
          ptr_q   <= '0;
        end else begin
          state_q <= state_d;
          owner_q <= owner_d;
          ptr_q   <= ptr_d;
        end
      end

      assign pair_busy[P]  = (state_q == SA_BUSY);
      assign pair_owner[P] = owner_q;
      assign pair_win[P]   = win_pulse;
      assign select_w[o][v] = (state_q == SA_BUSY) ? owner_q : '0;
      assign enable_w[o][v] = (state_q == SA_BUSY) && sa_if.valid[owner_q] &&
                              credit_avail[o][v] && !sa_if.reg_bank_claim;
    end
  end

  assign sa_if.select = select_w;
  assign sa_if.enable = enable_w;

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: 4-buffer table-driven run plus a 3-buffer wrap sequence.
module tb_switch_allocator;
  import switch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0]      req_a;
  logic [3:0][1:0] op_a;
  logic [3:0][0:0] vc_a;
  logic [3:0][1:0] credit_a;
  logic [3:0]      grant_a;

  switch_allocator_if #(.NUM_BUFFERS(4), .NUM_OUTPORTS(4), .NUM_VCS(2)) if_a ();

  switch_allocator #(.NUM_BUFFERS(4), .NUM_OUTPORTS(4), .NUM_VCS(2)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .req          (req_a),
    .req_outport  (op_a),
    .req_vc       (vc_a),
    .credit_avail (credit_a),
    .grant        (grant_a),
    .sa_if        (if_a)
  );

  logic [2:0]      req_b;
  logic [2:0][1:0] op_b;
  logic [2:0][0:0] vc_b;
  logic [3:0][1:0] credit_b;
  logic [2:0]      grant_b;

  switch_allocator_if #(.NUM_BUFFERS(3), .NUM_OUTPORTS(4), .NUM_VCS(2)) if_b ();

  switch_allocator #(.NUM_BUFFERS(3), .NUM_OUTPORTS(4), .NUM_VCS(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .req          (req_b),
    .req_outport  (op_b),
    .req_vc       (vc_b),
    .credit_avail (credit_b),
    .grant        (grant_b),
    .sa_if        (if_b)
  );

  // Pair p = o*2+v: select field [2p+:2], enable bit p, credit bit p; buffer i outport [2i+:2].
  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [7:0] op;
    logic [3:0] vc;
    logic [3:0] valid;
    logic [7:0] credit;
    logic       claim;
    logic [3:0]  eg;
    logic [15:0] es;
    logic [7:0]  ee;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic r, input logic [3:0] rq, input logic [7:0] op,
                     input logic [3:0] vc, input logic [3:0] vl, input logic [7:0] cr,
                     input logic cl, input logic [3:0] eg, input logic [15:0] es,
                     input logic [7:0] ee);
    vec_t t;
    t.name = n; t.rst = r; t.req = rq; t.op = op; t.vc = vc; t.valid = vl;
    t.credit = cr; t.claim = cl; t.eg = eg; t.es = es; t.ee = ee;
    vecs.push_back(t);
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, " grant"},  32'(grant_a),     32'(e.eg));
      chk({e.name, " select"}, 32'(if_a.select), 32'(e.es));
      chk({e.name, " enable"}, 32'(if_a.enable), 32'(e.ee));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_a = '0; op_a = '0; vc_a = '0; credit_a = '1;
    if_a.valid = '0; if_a.reg_bank_claim = 1'b0;
    req_b = '0; op_b = '0; vc_b = '0; credit_b = '1;
    if_b.valid = '0; if_b.reg_bank_claim = 1'b0;

    //   name            rst req  op     vc    valid credit claim | grant select    enable
    add("rst0",          1, 4'hF, 8'h00, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("rst1",          1, 4'hF, 8'h00, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("rst_fall",      0, 4'hF, 8'h00, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("first_grant",   0, 4'hF, 8'h00, 4'h0, 4'h1, 8'hFF, 0,     4'h1, 16'h0000, 8'h01);
    add("rst_midpkt",    1, 4'hF, 8'h00, 4'h0, 4'h1, 8'hFF, 0,     4'h0, 16'h0000, 8'h01);
    add("rst_dropped",   0, 4'h0, 8'h00, 4'h0, 4'h1, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    // Contention on (1,0): buffers 0,2,3.
    add("cont_idle",     0, 4'hD, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("cont_g0",       0, 4'hD, 8'h51, 4'h0, 4'h1, 8'hFF, 0,     4'h1, 16'h0000, 8'h04);
    add("cont_rel0",     0, 4'hD, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("cont_bub0",     0, 4'hD, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("cont_g2",       0, 4'hD, 8'h51, 4'h0, 4'h4, 8'hFF, 0,     4'h4, 16'h0020, 8'h04);
    add("cont_rel2",     0, 4'hD, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0020, 8'h00);
    add("cont_bub2",     0, 4'hD, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("cont_g3",       0, 4'hD, 8'h51, 4'h0, 4'h8, 8'hFF, 0,     4'h8, 16'h0030, 8'h04);
    add("cont_rel3",     0, 4'hD, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0030, 8'h00);
    add("cont_bub3",     0, 4'hD, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("cont_wrap0",    0, 4'hD, 8'h51, 4'h0, 4'h1, 8'hFF, 0,     4'h1, 16'h0000, 8'h04);
    add("cont_end",      0, 4'h0, 8'h51, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("cont_idle2",    0, 4'h0, 8'h00, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    // Lock hold and credit loss on (2,1): buffers 1 and 3.
    add("lock_idle",     0, 4'hA, 8'h88, 4'hA, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("lock_g1",       0, 4'hA, 8'h88, 4'hA, 4'h2, 8'hFF, 0,     4'h2, 16'h0400, 8'h20);
    for (int k = 0; k < 5; k++)
      add("lock_hold",   0, 4'hA, 8'h88, 4'hA, 4'h2, 8'hFF, 0,     4'h0, 16'h0400, 8'h20);
    for (int k = 0; k < 3; k++)
      add("credit_low",  0, 4'hA, 8'h88, 4'hA, 4'h2, 8'hDF, 0,     4'h0, 16'h0400, 8'h00);
    add("credit_back",   0, 4'hA, 8'h88, 4'hA, 4'h2, 8'hFF, 0,     4'h0, 16'h0400, 8'h20);
    add("lock_rel",      0, 4'hA, 8'h88, 4'hA, 4'h0, 8'hFF, 0,     4'h0, 16'h0400, 8'h00);
    add("lock_bub",      0, 4'hA, 8'h88, 4'hA, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("lock_g3",       0, 4'hA, 8'h88, 4'hA, 4'h8, 8'hFF, 0,     4'h8, 16'h0C00, 8'h20);
    add("lock_end",      0, 4'h0, 8'h88, 4'hA, 4'h0, 8'hFF, 0,     4'h0, 16'h0C00, 8'h00);
    add("lock_idle2",    0, 4'h0, 8'h00, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    // reg_bank_claim: buffer 1 holds (3,0), buffer 2 pends on (0,1).
    add("claim_idle",    0, 4'h2, 8'h0C, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("claim_g1",      0, 4'h2, 8'h0C, 4'h0, 4'h2, 8'hFF, 0,     4'h2, 16'h1000, 8'h40);
    for (int k = 0; k < 4; k++)
      add("claim_on",    0, 4'h6, 8'h0C, 4'h4, 4'h2, 8'hFF, 1,     4'h0, 16'h1000, 8'h00);
    add("claim_off",     0, 4'h6, 8'h0C, 4'h4, 4'h2, 8'hFF, 0,     4'h0, 16'h1000, 8'h40);
    add("claim_pend",    0, 4'h6, 8'h0C, 4'h4, 4'h6, 8'hFF, 0,     4'h4, 16'h1008, 8'h42);
    add("claim_rel",     0, 4'h6, 8'h0C, 4'h4, 4'h4, 8'hFF, 1,     4'h0, 16'h1008, 8'h00);
    add("claim_after",   0, 4'h4, 8'h0C, 4'h4, 4'h4, 8'hFF, 0,     4'h0, 16'h0008, 8'h02);
    add("claim_end",     0, 4'h0, 8'h0C, 4'h4, 4'h0, 8'hFF, 0,     4'h0, 16'h0008, 8'h00);
    add("claim_idle2",   0, 4'h0, 8'h00, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    // Parallel: four buffers on four distinct pairs.
    add("par_idle",      0, 4'hF, 8'hE4, 4'hA, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);
    add("par_grant",     0, 4'hF, 8'hE4, 4'hA, 4'hF, 8'hFF, 0,     4'hF, 16'hC240, 8'h99);
    add("par_end",       0, 4'h0, 8'hE4, 4'hA, 4'h0, 8'hFF, 0,     4'h0, 16'hC240, 8'h00);
    add("par_idle2",     0, 4'h0, 8'h00, 4'h0, 4'h0, 8'hFF, 0,     4'h0, 16'h0000, 8'h00);

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk); #1;
      rst                 = vecs[k].rst;
      req_a               = vecs[k].req;
      op_a                = vecs[k].op;
      vc_a                = vecs[k].vc;
      credit_a            = vecs[k].credit;
      if_a.valid          = vecs[k].valid;
      if_a.reg_bank_claim = vecs[k].claim;
      sb.push_back(vecs[k]);
    end
    @(posedge clk); #1;
    req_a = '0; if_a.valid = '0;

    // Three buffers contend for (0,0): winners 0,1,2 then wrap back to 0.
    for (int k = 0; k < 4; k++) begin
      int unsigned w;
      w = k % 3;
      req_b = '1; if_b.valid = '0;
      @(negedge clk);
      chk("b3_idle grant", 32'(grant_b), 32'd0);
      @(posedge clk); #1;
      if_b.valid = 3'(1 << w);
      @(negedge clk);
      chk("b3_win grant",  32'(grant_b), 32'(1 << w));
      chk("b3_win select", 32'(if_b.select[0][0]), 32'(w));
      chk("b3_win enable", 32'(if_b.enable[0][0]), 32'd1);
      @(posedge clk); #1;
      if_b.valid = '0;
      @(negedge clk);
      chk("b3_rel grant",  32'(grant_b), 32'd0);
      chk("b3_rel enable", 32'(if_b.enable), 32'd0);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
